// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module  : alu_pipe
// Brief   : Two-stage pipelined N-bit ALU with valid/ready flow control,
//           registered flags, sticky overflow and completed-op counter.
// Revision: 1.0
// ============================================================================
module alu_pipe #(
    parameter int N  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  A,
    input  logic [N-1:0]  B,
    input  logic          Cin,
    input  logic [2:0]    Op,
    input  logic          invA,
    input  logic          invB,
    input  logic          sign,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  Out,
    output logic          Zero,
    output logic          Ofl,
    output logic          ofl_sticky,
    input  logic          ofl_clr,
    output logic [CW-1:0] op_cnt
);

    localparam int SW = $clog2(N);

    localparam logic [2:0] C_OP_RLL = 3'b000;
    localparam logic [2:0] C_OP_SLL = 3'b001;
    localparam logic [2:0] C_OP_SRA = 3'b010;
    localparam logic [2:0] C_OP_SRL = 3'b011;
    localparam logic [2:0] C_OP_ADD = 3'b100;
    localparam logic [2:0] C_OP_OR  = 3'b101;
    localparam logic [2:0] C_OP_XOR = 3'b110;
    localparam logic [2:0] C_OP_AND = 3'b111;

    // Stage 1 holds the conditioned operands, stage 2 holds the result.
    logic          s1_v_q,   s1_v_d;
    logic [N-1:0]  ai_q,     ai_d;
    logic [N-1:0]  bi_q,     bi_d;
    logic          cin_q,    cin_d;
    logic [2:0]    op_q,     op_d;
    logic          sign_q,   sign_d;
    logic          s2_v_q,   s2_v_d;
    logic [N-1:0]  out_q,    out_d;
    logic          zero_q,   zero_d;
    logic          ofl_q,    ofl_d;
    logic          sticky_q, sticky_d;
    logic [CW-1:0] cnt_q,    cnt_d;

    logic          s2_rdy;
    logic          s1_rdy;
    logic          xfer;

    logic [SW-1:0]  sh;
    logic [2*N-1:0] rot_full;
    logic [N:0]     sum_full;
    logic [N-1:0]   sum_low;
    logic           carry_msb;
    logic [N-1:0]   res;
    logic           res_ofl;

    assign s2_rdy = !s2_v_q || out_ready;
    assign s1_rdy = !s1_v_q || s2_rdy;
    assign xfer   = s2_v_q && out_ready;

    assign in_ready   = s1_rdy;
    assign out_valid  = s2_v_q;
    assign Out        = out_q;
    assign Zero       = zero_q;
    assign Ofl        = ofl_q;
    assign ofl_sticky = sticky_q;
    assign op_cnt     = cnt_q;

    always_comb begin
        sh        = bi_q[SW-1:0];
        rot_full  = {ai_q, ai_q} << sh;
        sum_full  = {1'b0, ai_q} + {1'b0, bi_q} + {{N{1'b0}}, cin_q};
        // Sum of the low N-1 bits exposes the carry into the MSB in its top bit.
        sum_low   = {1'b0, ai_q[N-2:0]} + {1'b0, bi_q[N-2:0]} + {{(N-1){1'b0}}, cin_q};
        carry_msb = sum_low[N-1];
        res       = '0;
        res_ofl   = 1'b0;
        case (op_q)
            C_OP_RLL: res = rot_full[2*N-1:N];
            C_OP_SLL: res = ai_q << sh;
            C_OP_SRA: res = $unsigned($signed(ai_q) >>> sh);
            C_OP_SRL: res = ai_q >> sh;
            C_OP_ADD: begin
                res     = sum_full[N-1:0];
                res_ofl = sign_q ? (carry_msb ^ sum_full[N]) : sum_full[N];
            end
            C_OP_OR:  res = ai_q | bi_q;
            C_OP_XOR: res = ai_q ^ bi_q;
            C_OP_AND: res = ai_q & bi_q;
            default:  res = '0;
        endcase
    end

    always_comb begin
        s1_v_d   = s1_v_q;
        ai_d     = ai_q;
        bi_d     = bi_q;
        cin_d    = cin_q;
        op_d     = op_q;
        sign_d   = sign_q;
        s2_v_d   = s2_v_q;
        out_d    = out_q;
        zero_d   = zero_q;
        ofl_d    = ofl_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;

        if (s1_rdy) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                ai_d   = invA ? ~A : A;
                bi_d   = invB ? ~B : B;
                cin_d  = Cin;
                op_d   = Op;
                sign_d = sign;
            end
        end

        if (s2_rdy) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                out_d  = res;
                zero_d = (res == '0);
                ofl_d  = res_ofl;
            end
        end

        if (xfer && ofl_q) begin
            sticky_d = 1'b1;
        end else if (ofl_clr) begin
            sticky_d = 1'b0;
        end

        if (xfer) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0;
            ai_q     <= '0;
            bi_q     <= '0;
            cin_q    <= 1'b0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            out_q    <= '0;
            zero_q   <= 1'b0;
            ofl_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            ai_q     <= ai_d;
            bi_q     <= bi_d;
            cin_q    <= cin_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            s2_v_q   <= s2_v_d;
            out_q    <= out_d;
            zero_q   <= zero_d;
            ofl_q    <= ofl_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
`default_nettype wire
